// File: rtl/proc_ctrl_pkg.sv
// Shared types and constants for the processor control path.
// Used by the interrupt sequencer and its memory-port interface.
package proc_ctrl_pkg;

  localparam int PC_W   = 32;
  localparam int DATA_W = 16;
  localparam int FLAG_W = 3;

  localparam logic [1:0] ADDR_SEL_PUSH = 2'd0;
  localparam logic [1:0] ADDR_SEL_POP  = 2'd1;
  localparam logic [1:0] ADDR_SEL_ABS  = 2'd2;

  typedef enum logic [3:0] {
    IDLE,
    DRAIN,
    PUSH_HI,
    PUSH_LO,
    PUSH_FL,
    VEC_LO,
    VEC_HI,
    JUMP,
    POP_FL,
    POP_LO,
    POP_HI,
    RESUME
  } seq_state_t;

  typedef enum logic {
    KIND_INT,
    KIND_RTI
  } seq_kind_t;

  // States that own the memory-stage request port.
  function automatic logic is_access(input seq_state_t s);
    return (s == PUSH_HI) || (s == PUSH_LO) || (s == PUSH_FL) ||
           (s == VEC_LO)  || (s == VEC_HI)  ||
           (s == POP_FL)  || (s == POP_LO)  || (s == POP_HI);
  endfunction

endpackage

// File: rtl/interrupt_sequencer_if.sv
// Request/grant port between the interrupt sequencer and the memory stage.
// Handshake: mem_req with its address/data stays stable until a cycle with mem_grant=1; that cycle completes the access and mem_rdata is valid in it.
interface interrupt_sequencer_if;
  import proc_ctrl_pkg::*;

  logic              mem_req;
  logic              mem_we;
  logic [1:0]        mem_addr_sel;
  logic [DATA_W-1:0] mem_addr_abs;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_grant;

  modport master (
    output mem_req, mem_we, mem_addr_sel, mem_addr_abs, mem_wdata,
    input  mem_rdata, mem_grant
  );

  modport slave (
    input  mem_req, mem_we, mem_addr_sel, mem_addr_abs, mem_wdata,
    output mem_rdata, mem_grant
  );
endinterface

// File: rtl/interrupt_sequencer.sv
// Interrupt entry / RTI exit sequencer: drains the pipeline, moves PC and flags
// through the stack via the memory stage, and redirects fetch.
module interrupt_sequencer
  import proc_ctrl_pkg::*;
#(
  parameter int unsigned       DRAIN_CYCLES = 3,
  parameter logic [DATA_W-1:0] VECTOR_ADDR  = 16'h0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                interrupt_signal,
  input  logic                rti_decoded,
  input  logic [PC_W-1:0]     return_pc,
  input  logic [FLAG_W-1:0]   flags,
  interrupt_sequencer_if.master mem_if,
  output logic                fetch_stall,
  output logic                flush_decode,
  output logic                pc_load,
  output logic [PC_W-1:0]     pc_load_value,
  output logic                flags_restore,
  output logic [FLAG_W-1:0]   flags_restore_value,
  output logic                busy,
  output seq_state_t          dbg_state
);

  localparam logic [3:0]        DRAIN_CNT   = 4'(DRAIN_CYCLES);
  localparam logic [DATA_W-1:0] VECTOR_HI_A = VECTOR_ADDR + 16'd1;

  seq_state_t        state_q, state_d;
  seq_kind_t         kind_q, kind_d;
  logic              irq_pending_q, irq_pending_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [PC_W-1:0]   ret_pc_q, ret_pc_d;
  logic [FLAG_W-1:0] flags_cap_q, flags_cap_d;
  logic [PC_W-1:0]   tgt_q, tgt_d;
  logic [FLAG_W-1:0] flags_pop_q, flags_pop_d;
  logic [PC_W-1:0]   pc_val_q, pc_val_d;
  logic [FLAG_W-1:0] flags_val_q, flags_val_d;

  logic              req;
  logic              we;
  logic [1:0]        addr_sel;
  logic [DATA_W-1:0] addr_abs;
  logic [DATA_W-1:0] wdata;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      kind_q        <= KIND_INT;
      irq_pending_q <= 1'b0;
      cnt_q         <= '0;
      ret_pc_q      <= '0;
      flags_cap_q   <= '0;
      tgt_q         <= '0;
      flags_pop_q   <= '0;
      pc_val_q      <= '0;
      flags_val_q   <= '0;
    end else begin
      state_q       <= state_d;
      kind_q        <= kind_d;
      irq_pending_q <= irq_pending_d;
      cnt_q         <= cnt_d;
      ret_pc_q      <= ret_pc_d;
      flags_cap_q   <= flags_cap_d;
      tgt_q         <= tgt_d;
      flags_pop_q   <= flags_pop_d;
      pc_val_q      <= pc_val_d;
      flags_val_q   <= flags_val_d;
    end
  end

  // Next-state and capture logic
  always_comb begin
    state_d       = state_q;
    kind_d        = kind_q;
    irq_pending_d = irq_pending_q | interrupt_signal;
    cnt_d         = cnt_q;
    ret_pc_d      = ret_pc_q;
    flags_cap_d   = flags_cap_q;
    tgt_d         = tgt_q;
    flags_pop_d   = flags_pop_q;
    pc_val_d      = pc_val_q;
    flags_val_d   = flags_val_q;

    unique case (state_q)
      IDLE: begin
        // Interrupt beats a simultaneous RTI; the RTI is re-fetched after return.
        if (irq_pending_q || interrupt_signal) begin
          state_d       = DRAIN;
          kind_d        = KIND_INT;
          irq_pending_d = 1'b0;
          cnt_d         = DRAIN_CNT;
          ret_pc_d      = return_pc;
          flags_cap_d   = flags;
        end else if (rti_decoded) begin
          state_d     = DRAIN;
          kind_d      = KIND_RTI;
          cnt_d       = DRAIN_CNT;
          ret_pc_d    = return_pc;
          flags_cap_d = flags;
        end
      end
      DRAIN: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = (kind_q == KIND_INT) ? PUSH_HI : POP_FL;
        end
      end
      PUSH_HI: if (mem_if.mem_grant) state_d = PUSH_LO;
      PUSH_LO: if (mem_if.mem_grant) state_d = PUSH_FL;
      PUSH_FL: if (mem_if.mem_grant) state_d = VEC_LO;
      VEC_LO: begin
        if (mem_if.mem_grant) begin
          tgt_d[15:0] = mem_if.mem_rdata;
          state_d     = VEC_HI;
        end
      end
      VEC_HI: begin
        if (mem_if.mem_grant) begin
          tgt_d[31:16] = mem_if.mem_rdata;
          pc_val_d     = {mem_if.mem_rdata, tgt_q[15:0]};
          state_d      = JUMP;
        end
      end
      JUMP: state_d = IDLE;
      POP_FL: begin
        if (mem_if.mem_grant) begin
          flags_pop_d = mem_if.mem_rdata[FLAG_W-1:0];
          state_d     = POP_LO;
        end
      end
      POP_LO: begin
        if (mem_if.mem_grant) begin
          tgt_d[15:0] = mem_if.mem_rdata;
          state_d     = POP_HI;
        end
      end
      POP_HI: begin
        // Visible outputs only change when the redirect pulse starts.
        if (mem_if.mem_grant) begin
          tgt_d[31:16] = mem_if.mem_rdata;
          pc_val_d     = {mem_if.mem_rdata, tgt_q[15:0]};
          flags_val_d  = flags_pop_q;
          state_d      = RESUME;
        end
      end
      RESUME: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy          = (state_q != IDLE);
    fetch_stall   = busy;
    flush_decode  = busy;
    pc_load       = (state_q == JUMP) || (state_q == RESUME);
    flags_restore = (state_q == RESUME);
    req           = is_access(state_q);
    we            = 1'b0;
    addr_sel      = ADDR_SEL_PUSH;
    addr_abs      = '0;
    wdata         = '0;

    unique case (state_q)
      PUSH_HI: begin
        we    = 1'b1;
        wdata = ret_pc_q[31:16];
      end
      PUSH_LO: begin
        we    = 1'b1;
        wdata = ret_pc_q[15:0];
      end
      PUSH_FL: begin
        we    = 1'b1;
        wdata = {13'b0, flags_cap_q};
      end
      VEC_LO: begin
        addr_sel = ADDR_SEL_ABS;
        addr_abs = VECTOR_ADDR;
      end
      VEC_HI: begin
        addr_sel = ADDR_SEL_ABS;
        addr_abs = VECTOR_HI_A;
      end
      POP_FL, POP_LO, POP_HI: addr_sel = ADDR_SEL_POP;
      default: ;
    endcase
  end

  assign mem_if.mem_req      = req;
  assign mem_if.mem_we       = we;
  assign mem_if.mem_addr_sel = addr_sel;
  assign mem_if.mem_addr_abs = addr_abs;
  assign mem_if.mem_wdata    = wdata;

  assign pc_load_value       = pc_val_q;
  assign flags_restore_value = flags_val_q;
  assign dbg_state           = state_q;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Bench for interrupt_sequencer: stack/vector memory responder plus a
// transaction-level reference model (expected-access queue per sequence).
module tb_interrupt_sequencer;
  import proc_ctrl_pkg::*;

  localparam int          DRAIN = 3;
  localparam logic [15:0] VA    = 16'h0000;

  typedef struct packed {
    logic        we;
    logic [1:0]  sel;
    logic [15:0] addr;
    logic [15:0] wdata;
  } acc_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        interrupt_signal;
  logic        rti_decoded;
  logic [31:0] return_pc;
  logic [2:0]  flags;
  logic        fetch_stall, flush_decode, pc_load, flags_restore, busy;
  logic [31:0] pc_load_value;
  logic [2:0]  flags_restore_value;
  seq_state_t  dbg_state;

  interrupt_sequencer_if mif();

  interrupt_sequencer #(.DRAIN_CYCLES(DRAIN), .VECTOR_ADDR(VA)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .interrupt_signal    (interrupt_signal),
    .rti_decoded         (rti_decoded),
    .return_pc           (return_pc),
    .flags               (flags),
    .mem_if              (mif),
    .fetch_stall         (fetch_stall),
    .flush_decode        (flush_decode),
    .pc_load             (pc_load),
    .pc_load_value       (pc_load_value),
    .flags_restore       (flags_restore),
    .flags_restore_value (flags_restore_value),
    .busy                (busy),
    .dbg_state           (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- memory + model state ----------------
  logic [15:0] ram [65536];
  logic [15:0] sp;
  int          hold_acc, hold_cyc, acc_cnt;
  bit          rand_grant;

  acc_t        exp_q[$];
  bit          m_busy, m_pend, m_rti;
  int          m_drain;
  logic [31:0] m_pc, m_last_pc;
  logic [2:0]  m_fl, m_last_fl;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: one sequence = drain bubbles, an ordered list of
  // accesses (each completes on grant), then a single redirect cycle.
  task automatic model_step(input bit irq, input bit rti, input bit r, input bit g);
    bit si, sr;
    if (r) begin
      m_busy = 0; m_pend = 0; m_drain = 0; exp_q.delete();
      m_last_pc = '0; m_last_fl = '0;
      return;
    end
    si = !m_busy && (m_pend || irq);
    sr = !m_busy && !si && rti;
    if (m_busy) begin
      if (m_drain > 0) m_drain--;
      else if (exp_q.size() > 0) begin
        if (g) void'(exp_q.pop_front());
      end else begin
        m_busy = 0;
        m_last_pc = m_pc;
        if (m_rti) m_last_fl = m_fl;
      end
    end
    if (si) m_pend = 0;
    else if (irq) m_pend = 1;
    if (si || sr) begin
      m_busy = 1; m_drain = DRAIN; m_rti = sr; exp_q.delete();
      if (si) begin
        exp_q.push_back(acc_t'{1'b1, ADDR_SEL_PUSH, 16'h0, return_pc[31:16]});
        exp_q.push_back(acc_t'{1'b1, ADDR_SEL_PUSH, 16'h0, return_pc[15:0]});
        exp_q.push_back(acc_t'{1'b1, ADDR_SEL_PUSH, 16'h0, {13'b0, flags}});
        exp_q.push_back(acc_t'{1'b0, ADDR_SEL_ABS, VA, 16'h0});
        exp_q.push_back(acc_t'{1'b0, ADDR_SEL_ABS, 16'(VA + 16'd1), 16'h0});
        m_pc = {ram[16'(VA + 16'd1)], ram[VA]};
      end else begin
        for (int i = 0; i < 3; i++) exp_q.push_back(acc_t'{1'b0, ADDR_SEL_POP, 16'h0, 16'h0});
        m_fl = ram[sp][2:0];
        m_pc = {ram[16'(sp + 16'd2)], ram[16'(sp + 16'd1)]};
      end
    end
  endtask

  task automatic compare();
    bit   exp_req, pulse;
    acc_t h;
    exp_req = m_busy && (m_drain == 0) && (exp_q.size() > 0);
    pulse   = m_busy && (m_drain == 0) && (exp_q.size() == 0);
    check("busy", busy, m_busy);
    check("stall", fetch_stall, m_busy);
    check("flush", flush_decode, m_busy);
    check("req", mif.mem_req, exp_req);
    if (exp_req && mif.mem_req) begin
      h = exp_q[0];
      check("we", mif.mem_we, h.we);
      check("sel", mif.mem_addr_sel, h.sel);
      if (h.sel == ADDR_SEL_ABS) check("abs", mif.mem_addr_abs, h.addr);
      if (h.we) check("wdata", mif.mem_wdata, h.wdata);
    end
    check("pc_load", pc_load, pulse);
    check("pc_val", pc_load_value, pulse ? m_pc : m_last_pc);
    check("fl_rst", flags_restore, pulse && m_rti);
    check("fl_val", flags_restore_value, (pulse && m_rti) ? m_fl : m_last_fl);
  endtask

  // ---------------- driver ----------------
  task automatic tick(input bit irq, input bit rti, input bit r);
    bit          g, req_s, we_s;
    logic [1:0]  sel_s;
    logic [15:0] wd_s, a;
    interrupt_signal = irq;
    rti_decoded      = rti;
    rst              = r;
    req_s = mif.mem_req; we_s = mif.mem_we; sel_s = mif.mem_addr_sel; wd_s = mif.mem_wdata;
    g = 1'b0;
    if (req_s === 1'b1) begin
      if (acc_cnt == hold_acc && hold_cyc > 0) begin
        hold_cyc--;
      end else if (rand_grant) g = ($urandom_range(0, 3) != 0);
      else g = 1'b1;
    end
    a = (sel_s == ADDR_SEL_ABS) ? mif.mem_addr_abs : sp;
    mif.mem_grant = g;
    mif.mem_rdata = g ? ram[a] : 16'($urandom);
    @(posedge clk);
    if (req_s === 1'b1 && g) begin
      acc_cnt++;
      if (we_s) begin
        sp = sp - 16'd1;
        ram[sp] = wd_s;
      end else if (sel_s == ADDR_SEL_POP) sp = sp + 16'd1;
    end
    model_step(irq, rti, r, g);
    #1;
    cyc++;
    compare();
  endtask

  task automatic wait_pc_load(input string tag, input int exp_n);
    int n = 0;
    do begin
      tick(0, 0, 0);
      n++;
    end while (pc_load !== 1'b1 && n < 60);
    check(tag, n, exp_n);
  endtask

  task automatic load_rti_stack();
    sp = 16'h8FFD;
    ram[16'h8FFD] = 16'h0005;
    ram[16'h8FFE] = 16'h2345;
    ram[16'h8FFF] = 16'h0001;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    for (int i = 0; i < 65536; i++) ram[i] = 16'h0;
    sp = 16'h8000; hold_acc = -1; hold_cyc = 0; acc_cnt = 0; rand_grant = 0;
    m_busy = 0; m_pend = 0; m_rti = 0; m_drain = 0;
    m_pc = '0; m_last_pc = '0; m_fl = '0; m_last_fl = '0;
    return_pc = '0; flags = '0;
    mif.mem_grant = 1'b0; mif.mem_rdata = '0;

    tick(0, 0, 1);
    tick(0, 0, 1);
    check("rst_busy", busy, 0);
    check("rst_pcv", pc_load_value, 0);
    tick(0, 0, 0);

    // Basic interrupt entry
    ram[VA] = 16'hBEEF; ram[16'(VA + 16'd1)] = 16'h0002;
    return_pc = 32'h0001_2345; flags = 3'b101;
    tick(1, 0, 0);
    wait_pc_load("int_lat", 8);
    check("int_pc", pc_load_value, 32'h0002_BEEF);
    check("push_fl", ram[sp], 16'h0005);
    check("push_lo", ram[16'(sp + 16'd1)], 16'h2345);
    check("push_hi", ram[16'(sp + 16'd2)], 16'h0001);
    tick(0, 0, 0);

    // Grant withheld for two cycles on the second push
    acc_cnt = 0; hold_acc = 1; hold_cyc = 2;
    tick(1, 0, 0);
    wait_pc_load("hold_lat", 10);
    check("hold_pc", pc_load_value, 32'h0002_BEEF);
    hold_acc = -1;
    tick(0, 0, 0);

    // RTI exit
    load_rti_stack();
    tick(0, 1, 0);
    wait_pc_load("rti_lat", 6);
    check("rti_pc", pc_load_value, 32'h0001_2345);
    check("rti_flr", flags_restore, 1);
    check("rti_flv", flags_restore_value, 3'b101);
    tick(0, 0, 0);

    // Interrupt arriving mid-RTI is taken right after RESUME
    load_rti_stack();
    tick(0, 1, 0);
    tick(0, 0, 0);
    tick(1, 0, 0);
    wait_pc_load("rti_irq_lat", 4);
    check("rti_irq_pc", pc_load_value, 32'h0001_2345);
    check("rti_irq_fl", flags_restore_value, 3'b101);
    return_pc = 32'h0055_AA11; flags = 3'b010;
    tick(0, 0, 0);
    check("gap_idle", busy, 0);
    tick(0, 0, 0);
    check("irq_taken", busy, 1);
    wait_pc_load("int2_lat", 8);
    check("int2_fl", ram[sp], 16'h0002);
    check("int2_lo", ram[16'(sp + 16'd1)], 16'hAA11);
    check("int2_hi", ram[16'(sp + 16'd2)], 16'h0055);
    tick(0, 0, 0);

    // Simultaneous interrupt and RTI: interrupt path wins
    return_pc = 32'h0000_1234; flags = 3'b011;
    tick(1, 1, 0);
    n = 0;
    do begin
      tick(0, 0, 0);
      n++;
    end while (mif.mem_req !== 1'b1 && n < 20);
    check("first_push_lat", n, 3);
    check("first_we", mif.mem_we, 1);
    check("first_sel", mif.mem_addr_sel, ADDR_SEL_PUSH);
    wait_pc_load("int3_lat", 5);
    check("int3_no_flr", flags_restore, 0);
    tick(0, 0, 0);

    // Reset during the vector fetch
    tick(1, 0, 0);
    n = 0;
    do begin
      tick(0, 0, 0);
      n++;
    end while (!(mif.mem_req === 1'b1 && mif.mem_addr_sel == ADDR_SEL_ABS) && n < 20);
    check("vec_reach", n, 6);
    tick(0, 0, 1);
    check("ab_busy", busy, 0);
    check("ab_req", mif.mem_req, 0);
    check("ab_we", mif.mem_we, 0);
    check("ab_sel", mif.mem_addr_sel, 0);
    check("ab_abs", mif.mem_addr_abs, 0);
    check("ab_wdata", mif.mem_wdata, 0);
    check("ab_pcv", pc_load_value, 0);
    check("ab_flv", flags_restore_value, 0);
    tick(1, 0, 0);
    wait_pc_load("post_rst_lat", 8);
    check("post_rst_pc", pc_load_value, 32'h0002_BEEF);
    tick(0, 0, 0);

    // Randomized traffic with random grant delays
    rand_grant = 1;
    ram[VA] = 16'($urandom); ram[16'(VA + 16'd1)] = 16'($urandom);
    for (int i = 0; i < 600; i++) begin
      return_pc = $urandom;
      flags     = 3'($urandom_range(0, 7));
      tick($urandom_range(0, 19) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 249) == 0);
    end
    for (int i = 0; i < 60; i++) tick(0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/interrupt_sequencer.md
Name: interrupt_sequencer

Overview:
- Control FSM for the 5-stage 16-bit processor.
- Sequences interrupt entry: drain the pipeline, push return PC and flags to the stack, load the 32-bit vector, redirect fetch.
- Sequences RTI exit: drain, pop flags and PC, redirect fetch.
- Owns a request/grant port into the memory stage and stalls/flushes the front end while active.

Parameters:
- DRAIN_CYCLES, 3, bubble cycles inserted before the first memory access so in-flight instructions retire (legal range 1..15).
- VECTOR_ADDR, 16'h0000, word address of vector low half; high half at VECTOR_ADDR+1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- interrupt_signal  in  1  level/pulse interrupt request.
- rti_decoded  in  1  RTI present in decode stage this cycle.
- return_pc  in  32  PC of oldest instruction to be flushed (resume address).
- flags  in  3  current flag register.
- mem_rdata  in  16  read data, valid in the cycle mem_grant=1.
- mem_grant  in  1  memory stage accepts the current request.
- mem_req  out  1  memory access request.
- mem_we  out  1  1=write (push), 0=read.
- mem_addr_sel  out  2  0=push (SP pre-decrement), 1=pop (SP post-increment), 2=absolute.
- mem_addr_abs  out  16  absolute address when mem_addr_sel=2.
- mem_wdata  out  16  push data.
- fetch_stall  out  1  hold PC, no fetch.
- flush_decode  out  1  inject bubble into decode/execute.
- pc_load  out  1  one-cycle pulse: fetch takes pc_load_value.
- pc_load_value  out  32  redirect target.
- flags_restore  out  1  one-cycle pulse: flag register takes flags_restore_value.
- flags_restore_value  out  3  popped flags.
- busy  out  1  FSM not IDLE.

Behaviour:
- Reset: state IDLE, irq_pending=0, counter=0.
- Reset values: all outputs 0, including pc_load_value and flags_restore_value. Reset mid-sequence aborts immediately; no partial-push recovery.
- irq_pending: set in any cycle interrupt_signal=1; multiple pulses merge. Cleared on the IDLE->DRAIN transition for an interrupt.
- IDLE: if irq_pending or interrupt_signal, go to DRAIN(kind=INT). Else if rti_decoded, go to DRAIN(kind=RTI).
  - Interrupt wins a simultaneous RTI; the RTI is flushed and re-executed after return.
  - On entry, capture return_pc and flags; load counter=DRAIN_CYCLES.
- Every non-IDLE state: busy=1, fetch_stall=1, flush_decode=1.
- DRAIN: decrement counter. At counter==1, go to PUSH_HI (INT) or POP_FL (RTI).
- Access states hold mem_req=1 and stable address/data until mem_grant=1, then advance. No timeout.
- INT path:
  - PUSH_HI: we=1, sel=0, wdata=ret_pc[31:16].
  - PUSH_LO: we=1, sel=0, wdata=ret_pc[15:0].
  - PUSH_FL: we=1, sel=0, wdata={13'b0,flags_cap}.
  - VEC_LO: we=0, sel=2, addr=VECTOR_ADDR; latch rdata into tgt[15:0].
  - VEC_HI: we=0, sel=2, addr=VECTOR_ADDR+1; latch rdata into tgt[31:16].
  - JUMP: pc_load=1, pc_load_value=tgt; then IDLE.
- RTI path:
  - POP_FL: sel=1; latch rdata[2:0].
  - POP_LO: sel=1; latch tgt[15:0].
  - POP_HI: sel=1; latch tgt[31:16].
  - RESUME: pc_load=1 and flags_restore=1 in the same cycle; then IDLE.
- Latency with mem_grant tied 1, DRAIN_CYCLES=3, irq sampled at edge T:
  - INT: DRAIN T+1..T+3, pushes T+4..T+6, vector reads T+7..T+8, pc_load at T+9, IDLE at T+10.
  - RTI: pc_load at T+7.
- Interrupt arriving while busy (either path): pending; taken from IDLE on the cycle after JUMP/RESUME. Never nested.
- rti_decoded while busy: ignored (decode is being flushed).
- pc_load_value and flags_restore_value hold their last value outside pulses.

Decomposition:
- Shared package proc_ctrl_pkg:
  - seq_state_t enum: IDLE, DRAIN, PUSH_HI, PUSH_LO, PUSH_FL, VEC_LO, VEC_HI, JUMP, POP_FL, POP_LO, POP_HI, RESUME.
  - Constants ADDR_SEL_PUSH=2'd0, ADDR_SEL_POP=2'd1, ADDR_SEL_ABS=2'd2.
  - PC_W=32, DATA_W=16, FLAG_W=3.
- No sub-module: single FSM plus a 4-bit drain counter and capture registers.

Test Plan:
- Interrupt, grant=1, return_pc=32'h0001_2345, flags=3'b101, vector mem {0:16'hBEEF,1:16'h0002}:
  - wdata sequence 16'h0001, 16'h2345, 16'h0005.
  - pc_load=1 with 32'h0002_BEEF at T+9.
  - fetch_stall/flush_decode high T+1..T+9.
- Grant withheld 2 cycles in PUSH_LO -> mem_req, sel=0, wdata=16'h2345 stable for 3 cycles; pc_load delayed to T+11.
- RTI, pops return 16'h0005, 16'h2345, 16'h0001 -> at T+7: pc_load=1 with 32'h0001_2345, flags_restore=1 with 3'b101.
- interrupt_signal pulsed at T+2 of an RTI sequence -> RESUME completes unchanged; next cycle IDLE->DRAIN for INT; return_pc recaptured.
- interrupt_signal and rti_decoded asserted same cycle -> INT path taken; first push observed at T+4; no pop issued.
- rst asserted during VEC_LO -> next cycle all outputs 0, busy=0; a following interrupt runs a full clean sequence.
